// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//   Serial pattern detector with a run controller. A configuration handshake
//   loads a pattern (up to MAXLEN bits), its length, an overlap mode and a
//   window length. The controller then examines 'window' valid serial bits,
//   pulses 'match' one cycle after each bit that completes the pattern,
//   counts matches (saturating, with a sticky overflow flag), and pulses
//   'done' when the window is exhausted. 'abort' ends a run early without a
//   done pulse.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   cfg_valid    configuration request
//   cfg_ready    high in IDLE: configuration can be accepted
//   cfg_pattern  target pattern; bit [len-1] is the first serial bit
//   cfg_len      pattern length (0 -> 1, >MAXLEN -> MAXLEN)
//   cfg_overlap  1 = overlapping matches, 0 = matched bits are consumed
//   cfg_window   number of serial bits to examine in the run
//   bit_valid    bit_in is valid this cycle
//   bit_in       serial data bit
//   abort        terminate the current run (RUN only)
//   match        one-cycle detection pulse, one cycle after the matching bit
//   match_count  matches in the current or last run (saturating)
//   busy         run in progress
//   done         one-cycle run-complete pulse
//   overflow     sticky: a match arrived while match_count was saturated
//
// MAXLEN must be at least 2 (the history shift keeps MAXLEN-1 old bits).
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [15:0]       cfg_window,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              abort,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Run configuration
  logic [MAXLEN-1:0] pattern_q;
  logic [LW-1:0]     len_q;
  logic              overlap_q;
  logic [15:0]       window_q;

  // Run progress
  logic [MAXLEN-1:0] hist_q;
  logic [LW-1:0]     fill_q;
  logic [15:0]       bit_cnt_q;
  logic              match_q;
  logic [CNTW-1:0]   count_q;
  logic              overflow_q;

  // Combinational helpers
  logic [LW-1:0]     len_eff;
  logic [MAXLEN-1:0] len_mask;
  logic [MAXLEN-1:0] hist_next;
  logic [LW-1:0]     fill_inc;
  logic              cfg_fire;
  logic              accept;
  logic              hit;
  logic              last_bit;
  logic              count_max;

  // Effective length: zero means a single bit, anything longer than the
  // history register is cut down to MAXLEN.
  always_comb begin
    if (cfg_len == 4'd0) begin
      len_eff = LW'(1);
    end else if (32'(cfg_len) > 32'(MAXLEN)) begin
      len_eff = LW'(MAXLEN);
    end else begin
      len_eff = LW'(cfg_len);
    end
  end

  // Mask selecting the low len_q bits of history and pattern.
  // NOTE: every always_comb output gets a value before any branch or loop;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign cfg_fire  = (state == IDLE) && cfg_valid;

  // A zero-length window accepts no bits at all: the run ends on its first
  // cycle. abort wins over a simultaneous bit.
  assign accept    = (state == RUN) && !abort && (window_q != 16'd0) && bit_valid;

  assign hist_next = {hist_q[MAXLEN-2:0], bit_in};
  assign fill_inc  = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + LW'(1);

  // The fill count guards against matching on bits left over from before the
  // run started or, in non-overlap mode, bits already consumed by a match.
  assign hit       = accept
                   && (((hist_next ^ pattern_q) & len_mask) == '0)
                   && (fill_inc >= len_q);

  assign last_bit  = accept && (({1'b0, bit_cnt_q} + 17'd1) == {1'b0, window_q});
  assign count_max = (count_q == '1);

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_valid) state_next = RUN;
      end
      RUN: begin
        if (abort)                       state_next = IDLE;
        else if (window_q == 16'd0)      state_next = DONE;
        else if (last_bit)               state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the configuration registers are reset along with the run state so
  // nothing downstream ever sees X before the first configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q  <= '0;
      len_q      <= LW'(1);
      overlap_q  <= 1'b0;
      window_q   <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      match_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (cfg_fire) begin
        pattern_q  <= cfg_pattern;
        len_q      <= len_eff;
        overlap_q  <= cfg_overlap;
        window_q   <= cfg_window;
        hist_q     <= '0;
        fill_q     <= '0;
        bit_cnt_q  <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        hist_q    <= hist_next;
        bit_cnt_q <= bit_cnt_q + 16'd1;
        if (hit && !overlap_q) fill_q <= '0;
        else                   fill_q <= fill_inc;
        if (hit) begin
          if (count_max) overflow_q <= 1'b1;
          else           count_q    <= count_q + CNTW'(1);
        end
      end
    end
  end

  assign cfg_ready   = (state == IDLE);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign match       = match_q;
  assign match_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Self-checking bench for seq_detect_ctrl. A behavioural model keeps the
//   received bits of a run in a queue and decides matches by comparing the
//   queue tail against the pattern; it is checked against the DUT on every
//   cycle. Directed scenarios pin the model with literal expectations, and a
//   second instance with CNTW=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  localparam int MAXLEN  = 8;
  localparam int CNTW    = 8;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [3:0]        cfg_len;
  logic              cfg_overlap;
  logic [15:0]       cfg_window;
  logic              bit_valid;
  logic              bit_in;
  logic              abort;

  logic              cfg_ready, match, busy, done, overflow;
  logic [CNTW-1:0]   match_count;
  logic              cfg_ready2, match2, busy2, done2, overflow2;
  logic [1:0]        match_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .bit_valid(bit_valid), .bit_in(bit_in), .abort(abort),
    .match(match), .match_count(match_count), .busy(busy), .done(done),
    .overflow(overflow)
  );

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .bit_valid(bit_valid), .bit_in(bit_in), .abort(abort),
    .match(match2), .match_count(match_count2), .busy(busy2), .done(done2),
    .overflow(overflow2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase of the run, received bits of the run in a queue,
  // and the index of the last consumed bit in non-overlap mode.
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;

  phase_t            ph = P_IDLE;
  int                m_len = 1, m_win = 0, m_cnt = 0, m_last_end = 0;
  bit                m_ovl = 1'b0, m_ovf = 1'b0, m_match = 1'b0;
  logic [MAXLEN-1:0] m_pat = '0;
  bit                q_bits[$];
  bit                chk_en = 1'b0;

  function automatic int clamp_len(input int len);
    if (len == 0) return 1;
    if (len > MAXLEN) return MAXLEN;
    return len;
  endfunction

  always @(posedge clk) begin
    bit hit;
    int k;
    hit = 1'b0;
    if (rst) begin
      ph = P_IDLE;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_last_end = 0;
      q_bits.delete();
    end else begin
      case (ph)
        P_IDLE: if (cfg_valid) begin
          m_pat = cfg_pattern;
          m_len = clamp_len(int'(cfg_len));
          m_ovl = cfg_overlap;
          m_win = int'(cfg_window);
          m_cnt = 0;
          m_ovf = 1'b0;
          m_last_end = 0;
          q_bits.delete();
          ph = P_RUN;
        end
        P_RUN: begin
          if (abort) ph = P_IDLE;
          else if (m_win == 0) ph = P_DONE;
          else if (bit_valid) begin
            q_bits.push_back(bit_in);
            k = q_bits.size();
            if (k - m_last_end >= m_len) begin
              hit = 1'b1;
              for (int i = 0; i < m_len; i++)
                if (q_bits[k-1-i] != m_pat[i]) hit = 1'b0;
            end
            if (hit) begin
              if (!m_ovl) m_last_end = k;
              if (m_cnt == CNT_MAX) m_ovf = 1'b1;
              else m_cnt++;
            end
            if (k == m_win) ph = P_DONE;
          end
        end
        P_DONE: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
    m_match = hit;
    chk_en  = 1'b1;
  end

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ready", cfg_ready, ph == P_IDLE);
      check("busy", busy, ph == P_RUN);
      check("done", done, ph == P_DONE);
      check("match", match, m_match);
      check("match_count", match_count, m_cnt);
      check("overflow", overflow, m_ovf);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus (all drives happen at the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    cfg_valid = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl, input int win);
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_overlap = ovl;
    cfg_window  = 16'(win);
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit ab);
    bit_valid = 1'b1;
    bit_in    = b;
    abort     = ab;
    @(negedge clk);
    bit_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // 7-bit stream 1001001 against pattern 1001, expected match after each bit
  task automatic run_1001(input bit ovl, input logic [6:0] exp_m, input int exp_cnt);
    logic [6:0] stream;
    stream = 7'b1001001;
    do_cfg(8'b0000_1001, 4, ovl, 7);
    for (int i = 0; i < 7; i++) begin
      send_bit(stream[6-i], 1'b0);
      check($sformatf("ovl%0d match after bit %0d", ovl, i + 1), match, exp_m[6-i]);
      check($sformatf("ovl%0d done after bit %0d", ovl, i + 1), done, i == 6);
    end
    check($sformatf("ovl%0d final count", ovl), match_count, exp_cnt);
    @(negedge clk);
    check($sformatf("ovl%0d back to idle", ovl), cfg_ready, 1'b1);
    check($sformatf("ovl%0d count held", ovl), match_count, exp_cnt);
  endtask

  initial begin
    logic [7:0] pat;
    int         len, eff, win, pos, guard;
    logic [3:0] s0101;

    rst = 1'b1;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cfg_window  = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset cfg_ready", cfg_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset match", match, 1'b0);
    check("reset match_count", match_count, 0);
    check("reset overflow", overflow, 1'b0);

    // Overlapping and non-overlapping detection of 1001 in 1001001
    run_1001(1'b1, 7'b0001001, 2);
    run_1001(1'b0, 7'b0001000, 1);

    // Saturation on the CNTW=2 instance: five matches, counter stops at 3
    do_cfg(8'b1, 1, 1'b1, 5);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, 1'b0);
      if (i == 2) begin
        check("sat count at 3 matches", match_count2, 3);
        check("sat no overflow yet", overflow2, 1'b0);
      end
      if (i == 3) check("sat overflow on 4th match", overflow2, 1'b1);
    end
    check("sat final count", match_count2, 3);
    check("sat final overflow", overflow2, 1'b1);
    check("sat done", done2, 1'b1);
    @(negedge clk);
    check("sat overflow sticky in idle", overflow2, 1'b1);

    // Zero window: done two cycles after the handshake, a bit offered is ignored
    do_cfg(8'b0000_1001, 4, 1'b1, 0);
    check("win0 busy", busy, 1'b1);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    check("win0 done", done, 1'b1);
    check("win0 count", match_count, 0);
    @(negedge clk);
    check("win0 idle", cfg_ready, 1'b1);

    // cfg_len=0 behaves as a single-bit pattern
    s0101 = 4'b0101;
    do_cfg(8'b1, 0, 1'b1, 4);
    for (int i = 0; i < 4; i++) send_bit(s0101[3-i], 1'b0);
    check("len0 count", match_count, 2);
    check("len0 done", done, 1'b1);
    @(negedge clk);

    // Abort together with bit 3: straight back to idle, no done
    do_cfg(8'b0000_1001, 4, 1'b1, 7);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    check("abort idle", cfg_ready, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort no done", done, 1'b0);
    check("abort count", match_count, 0);
    @(negedge clk);
    check("abort still no done", done, 1'b0);

    // Reset mid-run after one match
    do_cfg(8'b0000_1001, 4, 1'b1, 7);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("pre-rst count", match_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy, 1'b0);
    check("rst cfg_ready", cfg_ready, 1'b1);
    check("rst count", match_count, 0);
    check("rst no done", done, 1'b0);
    check("rst match", match, 1'b0);

    // Randomised runs, checked every cycle by the model
    for (int r = 0; r < 60; r++) begin
      pat = 8'($urandom);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 2) != 0) len = $urandom_range(1, 4);
      eff = clamp_len(len);
      win = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      do_cfg(pat, len, 1'($urandom_range(0, 1)), win);
      pos   = 0;
      guard = 0;
      while (busy && guard < 400) begin
        bit_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) bit_in = 1'($urandom);
        else bit_in = pat[eff - 1 - (pos % eff)];
        if (bit_valid) pos++;
        abort     = ($urandom_range(0, 99) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        cfg_valid = ($urandom_range(0, 9) == 0);
        cfg_pattern = 8'($urandom);
        @(negedge clk);
        guard++;
      end
      idle_inputs();
      rst = 1'b0;
      check($sformatf("run %0d terminates", r), busy, 1'b0);
      // DONE or IDLE cycle: bits and abort must be ignored
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      abort     = 1'($urandom);
      @(negedge clk);
      idle_inputs();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter MAXLEN, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter CNTW, default 8: match counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  controller can accept configuration.
REQ-007 SHALL have port cfg_pattern  input  MAXLEN  target pattern; bit [len-1] is the first serial bit, bit [0] the last.
REQ-008 SHALL have port cfg_len  input  4  pattern length.
REQ-009 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port cfg_window  input  16  number of serial bits to examine per run.
REQ-011 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-012 SHALL have port bit_in  input  1  serial data bit.
REQ-013 SHALL have port abort  input  1  terminate the current run.
REQ-014 SHALL have port match  output  1  one-cycle detection pulse.
REQ-015 SHALL have port match_count  output  CNTW  matches in the current or last run.
REQ-016 SHALL have port busy  output  1  run in progress.
REQ-017 SHALL have port done  output  1  one-cycle run-complete pulse.
REQ-018 SHALL have port overflow  output  1  sticky flag: counter saturated.

Function
REQ-019 SHALL implement the states IDLE, RUN and DONE; no other state is reachable, and any illegal encoding SHALL go to IDLE.
REQ-020 SHALL drive cfg_ready=1 only in IDLE; busy=1 only in RUN.
REQ-021 SHALL, on cfg_valid&&cfg_ready, latch pattern, len, overlap and window, clear history, fill count, bit count, match_count and overflow, then enter RUN on the next cycle.
REQ-022 SHALL clamp the effective length: cfg_len=0 is treated as 1; cfg_len>MAXLEN is treated as MAXLEN.
REQ-023 SHALL, in RUN on each bit_valid, shift bit_in into the history LSB ({hist[MAXLEN-2:0],bit_in}), increment the bit count, and increment the fill count saturating at MAXLEN.
REQ-024 SHALL declare a match when, after the shift, hist[len-1:0]==pattern[len-1:0] and fill count>=len.
REQ-025 SHALL register match, so that it is high exactly one cycle, in the cycle after the matching bit is accepted (Moore-style latency 1).
REQ-026 SHALL reset the fill count to 0 on a match when overlap=0, so matched bits are not reused; when overlap=1 the fill count SHALL be kept.
REQ-027 SHALL increment match_count on each match, saturating at 2^CNTW-1; a match arriving at saturation SHALL set overflow, which stays set until the next accepted configuration or reset.
REQ-028 SHALL ignore bit_valid in IDLE and DONE.
REQ-029 SHALL transition RUN->DONE on the cycle the bit count reaches cfg_window, and SHALL still evaluate that last bit for a match.
REQ-030 SHALL go RUN->DONE on the first RUN cycle when cfg_window=0, with match_count=0.
REQ-031 SHALL hold done=1 for exactly the one cycle in DONE, then return to IDLE.
REQ-032 SHALL, on abort in RUN, go to IDLE next cycle without a done pulse, keeping match_count.
REQ-033 SHALL let abort take priority over a simultaneous bit_valid, so that bit is not processed.
REQ-034 SHALL ignore abort outside RUN.
REQ-035 SHALL keep match_count and overflow stable after DONE or abort until the next accepted configuration.

Reset
REQ-036 SHALL, on rst, enter IDLE and set cfg_ready=1, busy=0, done=0, match=0, match_count=0, overflow=0, and clear history, fill count and bit count.
REQ-037 SHALL give rst priority over every other input, including mid-RUN; the run is discarded with no done pulse.

Verification
REQ-038 SHALL cover: pattern=1001, len=4, overlap=1, window=7, stream 1001001 -> match pulses after bits 4 and 7, match_count=2, done 1 cycle after bit 7.
REQ-039 SHALL cover: same stream with overlap=0 -> single match after bit 4, match_count=1.
REQ-040 SHALL cover: CNTW=2, pattern=1, len=1, window=5, stream 11111 -> match_count=3, overflow=1.
REQ-041 SHALL cover: window=0 -> done 2 cycles after cfg handshake, match_count=0; and cfg_len=0 with pattern=1, stream 0101 (window 4) -> match_count=2.
REQ-042 SHALL cover: abort asserted together with bit_valid on bit 3 of the 1001 run -> IDLE next cycle, no done, match_count=0, bit 3 not shifted.
REQ-043 SHALL cover: rst asserted mid-RUN -> next cycle busy=0, cfg_ready=1, match_count=0, no done pulse.
